instr_sequencer: RTL and testbench

Top-level control sequencer for the microcontroller datapath. It starts the fetch FSM and latches the fetched instruction word. It then decodes the opcode and dispatches exactly one execution FSM (load, store, move, add), holding its start high until that FSM reports done. Finally it clears the sub-FSMs and loops. This block is the only driver of the sub-FSM start and clear lines, so the shared bus has one owner at a time.

---
 rtl/mcu_pkg.sv | 41 ++++
 rtl/instr_decode.sv | 29 ++
 rtl/instr_sequencer.sv | 134 +++++++++++++
 tb/tb_instr_sequencer.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcu_pkg.sv
// Shared definitions for the microcontroller control sequencer.
package mcu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXEC,
    RETIRE,
    HALT,
    ERR
  } state_e;

  localparam int unsigned OP_W = 6;

  localparam logic [OP_W-1:0] OP_NOP   = 6'd0;
  localparam logic [OP_W-1:0] OP_LOAD  = 6'd1;
  localparam logic [OP_W-1:0] OP_STORE = 6'd2;
  localparam logic [OP_W-1:0] OP_MOVE  = 6'd3;
  localparam logic [OP_W-1:0] OP_ADD   = 6'd4;
  localparam logic [OP_W-1:0] OP_HALT  = 6'd63;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  // Instruction word layout: [17:12] opcode, [11:6] operand 1, [5:0] operand 2.
  localparam int unsigned IR_W       = 18;
  localparam int unsigned IR_FIELD_W = 6;
  localparam int unsigned IR_OP_LSB  = 12;
  localparam int unsigned IR_P1_LSB  = 6;
  localparam int unsigned IR_P2_LSB  = 0;

  // Bit positions inside the one-hot execution-unit select.
  localparam int unsigned SEL_W   = 4;
  localparam int unsigned SEL_LD  = 0;
  localparam int unsigned SEL_ST  = 1;
  localparam int unsigned SEL_MOV = 2;
  localparam int unsigned SEL_ADD = 3;

endpackage

// File: rtl/instr_decode.sv
// Combinational opcode decoder: one-hot execution-unit select plus class flags.
module instr_decode
  import mcu_pkg::*;
(
  input  logic [OP_W-1:0]  opcode,
  output logic [SEL_W-1:0] sel,
  output logic             is_nop,
  output logic             is_halt,
  output logic             is_illegal
);

  // Map each opcode to exactly one class; anything unlisted is illegal.
  always_comb begin
    sel        = '0;
    is_nop     = 1'b0;
    is_halt    = 1'b0;
    is_illegal = 1'b0;
    case (opcode)
      OP_NOP:   is_nop = 1'b1;
      OP_LOAD:  sel[SEL_LD] = 1'b1;
      OP_STORE: sel[SEL_ST] = 1'b1;
      OP_MOVE:  sel[SEL_MOV] = 1'b1;
      OP_ADD:   sel[SEL_ADD] = 1'b1;
      OP_HALT:  is_halt = 1'b1;
      default:  is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_sequencer.sv
// Top-level control sequencer: fetch, decode, dispatch one execution FSM, retire.
module instr_sequencer
  import mcu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 32,
  parameter int unsigned CNT_W       = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  output logic                  fetch_start,
  input  logic                  fetch_done,
  input  logic [IR_W-1:0]       ir,
  output logic [IR_FIELD_W-1:0] parameter1,
  output logic [IR_FIELD_W-1:0] parameter2,
  output logic                  ld_start,
  output logic                  st_start,
  output logic                  mov_start,
  output logic                  add_start,
  input  logic                  ld_done,
  input  logic                  st_done,
  input  logic                  mov_done,
  input  logic                  add_done,
  output logic                  sub_clr,
  output logic                  busy,
  output logic                  halted,
  output logic                  err,
  output logic [1:0]            err_code,
  output logic [CNT_W-1:0]      instr_count
);

  localparam int unsigned TmoW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYC - 1);

  state_e          state_q;
  logic [OP_W-1:0] opcode_q;
  logic [SEL_W-1:0] sel_q;
  logic [TmoW-1:0] tmo_q;
  logic [1:0]      err_code_q;

  logic [SEL_W-1:0] dec_sel;
  logic             dec_nop;
  logic             dec_halt;
  logic             dec_illegal;
  logic [SEL_W-1:0] done_vec;

  assign done_vec = {add_done, mov_done, st_done, ld_done};

  instr_decode u_decode (
    .opcode     (opcode_q),
    .sel        (dec_sel),
    .is_nop     (dec_nop),
    .is_halt    (dec_halt),
    .is_illegal (dec_illegal)
  );

  // Sequencer FSM with its operand, select, timeout and retire-count registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      opcode_q    <= '0;
      parameter1  <= '0;
      parameter2  <= '0;
      sel_q       <= '0;
      tmo_q       <= '0;
      err_code_q  <= ERR_NONE;
      instr_count <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (run) state_q <= FETCH;
        end
        FETCH: begin
          if (fetch_done) begin
            opcode_q   <= ir[IR_OP_LSB +: IR_FIELD_W];
            parameter1 <= ir[IR_P1_LSB +: IR_FIELD_W];
            parameter2 <= ir[IR_P2_LSB +: IR_FIELD_W];
            state_q    <= DECODE;
          end
        end
        DECODE: begin
          if (dec_illegal) begin
            err_code_q <= ERR_ILLEGAL;
            state_q    <= ERR;
          end else if (dec_halt) begin
            // HALT counts as retired even though it never passes RETIRE.
            instr_count <= instr_count + 1'b1;
            state_q     <= HALT;
          end else if (dec_nop) begin
            state_q <= RETIRE;
          end else begin
            sel_q   <= dec_sel;
            tmo_q   <= '0;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          // The selected done beats a timeout landing in the same cycle.
          if ((sel_q & done_vec) != '0) begin
            state_q <= RETIRE;
          end else if (tmo_q == TmoLast) begin
            err_code_q <= ERR_TIMEOUT;
            state_q    <= ERR;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        RETIRE: begin
          instr_count <= instr_count + 1'b1;
          state_q     <= run ? FETCH : IDLE;
        end
        HALT, ERR: begin
          state_q <= state_q;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Moore outputs decoded from registered state and select only.
  always_comb begin
    fetch_start = (state_q == FETCH);
    ld_start    = (state_q == EXEC) && sel_q[SEL_LD];
    st_start    = (state_q == EXEC) && sel_q[SEL_ST];
    mov_start   = (state_q == EXEC) && sel_q[SEL_MOV];
    add_start   = (state_q == EXEC) && sel_q[SEL_ADD];
    sub_clr     = (state_q == RETIRE);
    busy        = !((state_q == IDLE) || (state_q == HALT) || (state_q == ERR));
    halted      = (state_q == HALT);
    err         = (state_q == ERR);
    err_code    = err_code_q;
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer with randomized instruction streams.
module tb_instr_sequencer;

  localparam int TIMEOUT_CYC = 32;
  localparam int CNT_W       = 8;

  logic             clk;
  logic             rst;
  logic             run;
  logic             fetch_start;
  logic             fetch_done;
  logic [17:0]      ir;
  logic [5:0]       parameter1;
  logic [5:0]       parameter2;
  logic             ld_start, st_start, mov_start, add_start;
  logic [3:0]       done_vec;
  logic             sub_clr;
  logic             busy;
  logic             halted;
  logic             err;
  logic [1:0]       err_code;
  logic [CNT_W-1:0] instr_count;
  logic [3:0]       starts_vec;

  int checks = 0;
  int errors = 0;
  int exp_count;

  assign starts_vec = {add_start, mov_start, st_start, ld_start};

  instr_sequencer #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .CNT_W       (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .fetch_start (fetch_start),
    .fetch_done  (fetch_done),
    .ir          (ir),
    .parameter1  (parameter1),
    .parameter2  (parameter2),
    .ld_start    (ld_start),
    .st_start    (st_start),
    .mov_start   (mov_start),
    .add_start   (add_start),
    .ld_done     (done_vec[0]),
    .st_done     (done_vec[1]),
    .mov_done    (done_vec[2]),
    .add_done    (done_vec[3]),
    .sub_clr     (sub_clr),
    .busy        (busy),
    .halted      (halted),
    .err         (err),
    .err_code    (err_code),
    .instr_count (instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    run        = 1'b0;
    fetch_done = 1'b0;
    ir         = '0;
    done_vec   = '0;
    tick();
    tick();
    rst       = 1'b0;
    exp_count = 0;
  endtask

  // Wait (bounded) for fetch_start, then answer the fetch; ends sampled in DECODE.
  task automatic do_fetch(input logic [5:0] op, input logic [5:0] a, input logic [5:0] b,
                          input int fdly, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 64 && !fetch_start; i++) tick();
    if (!fetch_start) return;
    ok = 1'b1;
    repeat (fdly) tick();
    ir         = {op, a, b};
    fetch_done = 1'b1;
    tick();
    fetch_done = 1'b0;
    ir         = 18'($urandom);
  endtask

  // Act as the execution units from DECODE until no start is active.
  task automatic do_exec(input int unit, input int done_at, input int stray_unit,
                         input int stray_at, output int sel_c, output int oth_c);
    logic [3:0] mask;
    mask  = 4'b0001 << unit;
    sel_c = 0;
    oth_c = 0;
    tick();
    for (int c = 1; c <= 200; c++) begin
      if (starts_vec == 4'b0000) break;
      if ((starts_vec & mask) != 4'b0000) sel_c++;
      if ((starts_vec & ~mask) != 4'b0000) oth_c++;
      done_vec = '0;
      if (c == done_at) done_vec[unit] = 1'b1;
      if (c == stray_at) done_vec[stray_unit] = 1'b1;
      tick();
    end
    done_vec = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    checks++;
    if ({fetch_start, parameter1, parameter2, starts_vec, sub_clr, busy, halted, err,
         err_code, instr_count} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b err=%b cnt=%0d p1=%0d required all zero",
               busy, err, instr_count, parameter1);
    end
    do_reset();
    tick();
    checks++;
    if (busy !== 1'b0 || fetch_start !== 1'b0) begin
      errors++;
      $display("FAIL idle_without_run: busy=%b fetch_start=%b required 0 0", busy, fetch_start);
    end
  endtask

  task automatic test_load();
    bit ok;
    int sel_c, oth_c;
    do_reset();
    run = 1'b1;
    do_fetch(6'd1, 6'd2, 6'd5, 0, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL load_fetch_wait: fetch_start never rose, required 1");
    end
    do_exec(0, 3, 0, 0, sel_c, oth_c);
    checks++;
    if (sel_c !== 3 || oth_c !== 0) begin
      errors++;
      $display("FAIL load_start_len: ld=%0d other=%0d required 3 0", sel_c, oth_c);
    end
    checks++;
    if (parameter1 !== 6'd2 || parameter2 !== 6'd5) begin
      errors++;
      $display("FAIL load_params: p1=%0d p2=%0d required 2 5", parameter1, parameter2);
    end
    checks++;
    if (sub_clr !== 1'b1) begin
      errors++;
      $display("FAIL load_sub_clr: sub_clr=%b required 1", sub_clr);
    end
    tick();
    checks++;
    if (sub_clr !== 1'b0 || instr_count !== CNT_W'(1) || fetch_start !== 1'b1) begin
      errors++;
      $display("FAIL load_retire: sub_clr=%b cnt=%0d fetch_start=%b required 0 1 1",
               sub_clr, instr_count, fetch_start);
    end
  endtask

  task automatic test_random();
    bit ok;
    int sel_c, oth_c, op, fdly, done_at, unit, stray_unit, stray_at;
    logic [5:0] a, b;
    do_reset();
    run = 1'b1;
    for (int n = 0; n < 30; n++) begin
      op      = $urandom_range(0, 4);
      a       = 6'($urandom);
      b       = 6'($urandom);
      fdly    = $urandom_range(0, 3);
      done_at = ($urandom_range(0, 7) == 0) ? TIMEOUT_CYC : $urandom_range(1, 5);
      do_fetch(6'(op), a, b, fdly, ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL rand_fetch_wait[%0d]: fetch_start never rose", n);
      end
      checks++;
      if (parameter1 !== a || parameter2 !== b) begin
        errors++;
        $display("FAIL rand_params[%0d]: p1=%0d p2=%0d required %0d %0d",
                 n, parameter1, parameter2, a, b);
      end
      if (op == 0) begin
        tick();
      end else begin
        unit       = op - 1;
        stray_unit = (unit + 1 + $urandom_range(0, 2)) % 4;
        stray_at   = $urandom_range(0, done_at - 1);
        do_exec(unit, done_at, stray_unit, stray_at, sel_c, oth_c);
        checks++;
        if (sel_c !== done_at || oth_c !== 0) begin
          errors++;
          $display("FAIL rand_exec[%0d]: op=%0d sel=%0d other=%0d required %0d 0",
                   n, op, sel_c, oth_c, done_at);
        end
      end
      checks++;
      if (sub_clr !== 1'b1 || busy !== 1'b1) begin
        errors++;
        $display("FAIL rand_retire[%0d]: sub_clr=%b busy=%b required 1 1", n, sub_clr, busy);
      end
      tick();
      exp_count = (exp_count + 1) % (1 << CNT_W);
      checks++;
      if (instr_count !== CNT_W'(exp_count) || sub_clr !== 1'b0) begin
        errors++;
        $display("FAIL rand_count[%0d]: cnt=%0d sub_clr=%b required %0d 0",
                 n, instr_count, sub_clr, exp_count);
      end
    end
  endtask

  task automatic test_halt_seq();
    bit ok;
    int sel_c, oth_c;
    do_reset();
    run = 1'b1;
    do_fetch(6'd0, 6'd1, 6'd1, 0, ok);
    tick();
    tick();
    do_fetch(6'd4, 6'd9, 6'd3, 1, ok);
    do_exec(3, 2, 0, 1, sel_c, oth_c);
    checks++;
    if (sel_c !== 2 || oth_c !== 0) begin
      errors++;
      $display("FAIL halt_seq_add: add=%0d other=%0d required 2 0", sel_c, oth_c);
    end
    tick();
    do_fetch(6'd63, 6'd7, 6'd8, 0, ok);
    tick();
    checks++;
    if (halted !== 1'b1 || busy !== 1'b0 || instr_count !== CNT_W'(3)) begin
      errors++;
      $display("FAIL halt_state: halted=%b busy=%b cnt=%0d required 1 0 3",
               halted, busy, instr_count);
    end
    for (int i = 0; i < 5; i++) begin
      run        = 1'($urandom);
      fetch_done = 1'b1;
      ir         = 18'($urandom);
      done_vec   = 4'($urandom);
      tick();
      checks++;
      if ({halted, busy, fetch_start, starts_vec, err} !== 8'b1000_0000 ||
          instr_count !== CNT_W'(3) || parameter1 !== 6'd7 || parameter2 !== 6'd8) begin
        errors++;
        $display("FAIL halt_sticky[%0d]: halted=%b fetch_start=%b cnt=%0d p1=%0d required 1 0 3 7",
                 i, halted, fetch_start, instr_count, parameter1);
      end
    end
    fetch_done = 1'b0;
    done_vec   = '0;
  endtask

  task automatic test_illegal();
    bit ok;
    logic [5:0] op;
    for (int k = 0; k < 4; k++) begin
      op = (k == 0) ? 6'd7 : 6'($urandom_range(5, 62));
      do_reset();
      run = 1'b1;
      do_fetch(6'd0, 6'd0, 6'd0, 0, ok);
      tick();
      tick();
      do_fetch(op, 6'd11, 6'd22, 0, ok);
      tick();
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (err !== 1'b1 || err_code !== 2'b01 || starts_vec !== 4'b0000 || busy !== 1'b0 ||
            instr_count !== CNT_W'(1)) begin
          errors++;
          $display("FAIL illegal[%0d]: op=%0d err=%b code=%b starts=%b cnt=%0d required 1 01 0000 1",
                   k, op, err, err_code, starts_vec, instr_count);
        end
        done_vec = 4'b1111;
        tick();
      end
      done_vec = '0;
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int sel_c, oth_c;
    do_reset();
    run = 1'b1;
    do_fetch(6'd2, 6'd3, 6'd4, 2, ok);
    do_exec(1, 0, 0, 5, sel_c, oth_c);
    checks++;
    if (sel_c !== TIMEOUT_CYC || oth_c !== 0) begin
      errors++;
      $display("FAIL timeout_len: st=%0d other=%0d required %0d 0", sel_c, oth_c, TIMEOUT_CYC);
    end
    checks++;
    if (err !== 1'b1 || err_code !== 2'b10 || instr_count !== CNT_W'(0) || halted !== 1'b0) begin
      errors++;
      $display("FAIL timeout_err: err=%b code=%b cnt=%0d required 1 10 0", err, err_code,
               instr_count);
    end
  endtask

  task automatic test_run_drop();
    bit ok;
    int mov_c;
    do_reset();
    run = 1'b1;
    do_fetch(6'd3, 6'd5, 6'd6, 0, ok);
    mov_c = 0;
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (mov_start === 1'b1) mov_c++;
      if (c == 2) run = 1'b0;
      if (c == 4) done_vec[2] = 1'b1;
    end
    tick();
    done_vec = '0;
    checks++;
    if (mov_c !== 4 || sub_clr !== 1'b1) begin
      errors++;
      $display("FAIL run_drop_exec: mov=%0d sub_clr=%b required 4 1", mov_c, sub_clr);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (busy !== 1'b0 || fetch_start !== 1'b0 || instr_count !== CNT_W'(1)) begin
        errors++;
        $display("FAIL run_drop_idle[%0d]: busy=%b fetch_start=%b cnt=%0d required 0 0 1",
                 i, busy, fetch_start, instr_count);
      end
    end
  endtask

  task automatic test_async_reset();
    bit ok;
    do_reset();
    run = 1'b1;
    do_fetch(6'd1, 6'd33, 6'd44, 0, ok);
    tick();
    tick();
    checks++;
    if (ld_start !== 1'b1) begin
      errors++;
      $display("FAIL async_pre: ld_start=%b required 1", ld_start);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({fetch_start, parameter1, parameter2, starts_vec, sub_clr, busy, halted, err,
         err_code, instr_count} !== '0) begin
      errors++;
      $display("FAIL async_reset: ld_start=%b busy=%b p1=%0d required all zero",
               ld_start, busy, parameter1);
    end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_wrap();
    bit ok;
    do_reset();
    run = 1'b1;
    for (int n = 0; n < 256; n++) begin
      do_fetch(6'd0, 6'($urandom), 6'($urandom), 0, ok);
      tick();
      tick();
      exp_count = (exp_count + 1) % (1 << CNT_W);
      if (n == 254 || n == 255) begin
        checks++;
        if (instr_count !== CNT_W'(exp_count)) begin
          errors++;
          $display("FAIL wrap[%0d]: cnt=%0d required %0d", n, instr_count, exp_count);
        end
      end
    end
  endtask

  initial begin
    rst        = 1'b1;
    run        = 1'b0;
    fetch_done = 1'b0;
    ir         = '0;
    done_vec   = '0;
    exp_count  = 0;
    test_reset();
    test_load();
    test_random();
    test_halt_seq();
    test_illegal();
    test_timeout();
    test_run_drop();
    test_async_reset();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
